// File: rtl/fir_pkg.sv
// Shared types for the FIR + SSE stimulus path.
// Sample words and buffered (sample, golden, last) entries.
package fir_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] sample_t;

    typedef struct packed {
        logic    last;
        sample_t gold;
        sample_t in;
    } stream_entry_t;

endpackage

// File: rtl/fir_fifo.sv
// Single-clock FIFO with occupancy count and registered read data.
// Full/empty come from the level counter; pointers simply wrap.
module fir_fifo
    import fir_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = stream_entry_t,
    localparam int LVL_W   = $clog2(DEPTH + 1),
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  entry_t           wdata,
    output entry_t           rdata,
    output logic [LVL_W-1:0] level
);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    entry_t             rdata_q, rdata_d;
    logic               do_push;
    logic               do_pop;

    // Pointer, level and read-data next state
    always_comb begin
        do_push = push && !rst && (level_q != LVL_W'(DEPTH));
        do_pop  = pop && !rst && (level_q != '0);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        rdata_d = rdata_q;
        if (do_push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rptr_d  = rptr_q + PTR_W'(1);
            rdata_d = mem[rptr_q];
        end
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Control registers; storage is left uninitialised on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            rdata_q <= rdata_d;
        end
    end

    // Entry storage write port
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

    assign rdata = rdata_q;
    assign level = level_q;

endmodule

// File: rtl/sample_streamer.sv
// Feeds buffered (sample, golden) pairs to the FIR datapath on request.
// Tracks end of stream, issued count and sticky overflow/underrun.
module sample_streamer
    import fir_pkg::*;
#(
    parameter int  DATA_W = fir_pkg::DATA_W,
    parameter int  DEPTH  = 16,
    parameter int  CNT_W  = 32,
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_in,
    input  logic [DATA_W-1:0] wr_gold,
    input  logic              wr_last,
    output logic              wr_ready,
    input  logic              next,
    output logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out_gold,
    output logic              valid,
    output logic              stop,
    output logic [LVL_W-1:0]  level,
    output logic [CNT_W-1:0]  issued,
    output logic              overflow,
    output logic              underrun
);

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] gold;
        logic [DATA_W-1:0] in;
    } entry_t;

    entry_t             wdata;
    entry_t             rdata;
    logic               push;
    logic               pop;
    logic               closed_q, closed_d;
    logic               stop_q, stop_d;
    logic               valid_q, valid_d;
    logic               overflow_q, overflow_d;
    logic               underrun_q, underrun_d;
    logic [CNT_W-1:0]   issued_q, issued_d;

    assign wdata    = '{last: wr_last, gold: wr_gold, in: wr_in};
    assign wr_ready = !rst && !closed_q && (level != LVL_W'(DEPTH));
    assign push     = wr_en && wr_ready;
    assign pop      = next && !rst && !stop_q && (level != '0);

    fir_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .level (level)
    );

    // Stream flags, valid pulse and issued counter next state
    always_comb begin
        closed_d   = closed_q;
        stop_d     = stop_q;
        valid_d    = 1'b0;
        overflow_d = overflow_q;
        underrun_d = underrun_q;
        issued_d   = issued_q;
        if (rst) begin
            closed_d   = 1'b0;
            stop_d     = 1'b0;
            overflow_d = 1'b0;
            underrun_d = 1'b0;
            issued_d   = '0;
        end else begin
            if (push && wr_last) begin
                closed_d = 1'b1;
            end
            if (wr_en && !wr_ready) begin
                overflow_d = 1'b1;
            end
            if (next && !stop_q && (level == '0)) begin
                underrun_d = 1'b1;
            end
            if (valid_q && rdata.last) begin
                stop_d = 1'b1;
            end
            if (pop) begin
                valid_d  = 1'b1;
                issued_d = issued_q + CNT_W'(1);
            end
        end
    end

    // Flag and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            closed_q   <= 1'b0;
            stop_q     <= 1'b0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
            issued_q   <= '0;
        end else begin
            closed_q   <= closed_d;
            stop_q     <= stop_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
            issued_q   <= issued_d;
        end
    end

    assign in       = rdata.in;
    assign out_gold = rdata.gold;
    assign valid    = valid_q;
    assign stop     = stop_q;
    assign issued   = issued_q;
    assign overflow = overflow_q;
    assign underrun = underrun_q;

endmodule
